lcd_status_writer: RTL and testbench

HD44780-compatible character-LCD writer that sits directly downstream of the `fsm` stage and consumes its `t` and `f` outputs. After power-up it runs the controller init sequence, then keeps line 1 of the panel showing `T=<t> F=<f>` as ASCII digits, rewriting it whenever either input changes. It drives the LCD data, RS, RW and E pins. Panel power and backlight enables stay at the top level.

---
 rtl/lcd_status_writer.sv | 185 ++++++++++++++++++
 tb/tb_lcd_status_writer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_status_writer.sv
// HD44780 line-1 status writer: powers up the panel, then keeps "T=<t> F=<f>"
// on line 1. The line is rewritten whenever the {t, f} pair changes.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// PWR_WAIT | power-up delay before the first command
// INIT     | function set, display on, clear, entry mode
// ADDR     | snapshot {t, f}, set DDRAM address to line 1 column 0
// TEXT     | seven character bytes built from the snapshot
// IDLE     | panel matches snapshot; wait for an input change
//
// Every byte runs SETUP (2 cycles) -> STROBE (E_HIGH) -> HOLD (settle time).
module lcd_status_writer #(
   parameter int INIT_WAIT = 750000,
   parameter int E_HIGH    = 25,
   parameter int CMD_WAIT  = 2500,
   parameter int CLR_WAIT  = 100000
) (
   input  logic       clk_50MHZ,
   input  logic       reset,
   input  logic       t,
   input  logic       f,
   inout  wire  [7:0] DATA_BUS,
   output logic       LCD_RW,
   output logic       LCD_E,
   output logic       LCD_RS,
   output logic       ready
);

   typedef enum logic [2:0] {PWR_WAIT, INIT, ADDR, TEXT, IDLE} state_t;
   typedef enum logic [1:0] {SETUP, STROBE, HOLD} phase_t;

   localparam logic [19:0] INIT_LIM = 20'(INIT_WAIT - 1);
   localparam logic [19:0] E_LIM    = 20'(E_HIGH - 1);
   localparam logic [19:0] CMD_LIM  = 20'(CMD_WAIT - 1);
   localparam logic [19:0] CLR_LIM  = 20'(CLR_WAIT - 1);

   state_t      state;
   phase_t      phase;
   logic [19:0] cnt;
   logic [19:0] hold_lim;
   logic [2:0]  idx;
   logic [1:0]  snap;
   logic [7:0]  data_q;
   logic        rs_q;
   logic        e_q;
   logic        ready_q;

   function automatic logic [7:0] init_byte(input logic [2:0] i);
      case (i)
         3'd0:    return 8'h38;
         3'd1:    return 8'h0C;
         3'd2:    return 8'h01;
         default: return 8'h06;
      endcase
   endfunction

   function automatic logic [7:0] text_byte(input logic [2:0] i, input logic [1:0] s);
      case (i)
         3'd0:    return 8'h54;
         3'd1:    return 8'h3D;
         3'd2:    return 8'h30 | {7'd0, s[1]};
         3'd3:    return 8'h20;
         3'd4:    return 8'h46;
         3'd5:    return 8'h3D;
         default: return 8'h30 | {7'd0, s[0]};
      endcase
   endfunction

   // Clear display needs the long settle time; everything else uses the short one.
   always_comb begin
      hold_lim = CMD_LIM;
      if (state == INIT && idx == 3'd2) hold_lim = CLR_LIM;
   end

   // Main sequencer: state, byte phase, counters and all registered pin values.
   always_ff @(posedge clk_50MHZ) begin
      if (reset) begin
         state   <= PWR_WAIT;
         phase   <= SETUP;
         cnt     <= 20'd0;
         idx     <= 3'd0;
         snap    <= 2'b00;
         data_q  <= 8'h00;
         rs_q    <= 1'b0;
         e_q     <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         case (state)
            PWR_WAIT: begin
               if (cnt == INIT_LIM) begin
                  cnt    <= 20'd0;
                  state  <= INIT;
                  phase  <= SETUP;
                  idx    <= 3'd0;
                  data_q <= init_byte(3'd0);
                  rs_q   <= 1'b0;
               end else begin
                  cnt <= cnt + 20'd1;
               end
            end
            IDLE: begin
               // Live inputs are compared here, so changes made during a
               // write coalesce into at most one further refresh.
               if ({t, f} != snap) begin
                  state   <= ADDR;
                  snap    <= {t, f};
                  ready_q <= 1'b0;
                  phase   <= SETUP;
                  cnt     <= 20'd0;
                  data_q  <= 8'h80;
                  rs_q    <= 1'b0;
               end
            end
            default: begin
               case (phase)
                  SETUP: begin
                     if (cnt == 20'd1) begin
                        cnt   <= 20'd0;
                        phase <= STROBE;
                        e_q   <= 1'b1;
                     end else begin
                        cnt <= cnt + 20'd1;
                     end
                  end
                  STROBE: begin
                     if (cnt == E_LIM) begin
                        cnt   <= 20'd0;
                        phase <= HOLD;
                        e_q   <= 1'b0;
                     end else begin
                        cnt <= cnt + 20'd1;
                     end
                  end
                  default: begin
                     if (cnt == hold_lim) begin
                        cnt   <= 20'd0;
                        phase <= SETUP;
                        case (state)
                           INIT: begin
                              if (idx == 3'd3) begin
                                 state  <= ADDR;
                                 snap   <= {t, f};
                                 idx    <= 3'd0;
                                 data_q <= 8'h80;
                                 rs_q   <= 1'b0;
                              end else begin
                                 idx    <= idx + 3'd1;
                                 data_q <= init_byte(idx + 3'd1);
                              end
                           end
                           ADDR: begin
                              state  <= TEXT;
                              idx    <= 3'd0;
                              data_q <= text_byte(3'd0, snap);
                              rs_q   <= 1'b1;
                           end
                           TEXT: begin
                              if (idx == 3'd6) begin
                                 state   <= IDLE;
                                 ready_q <= 1'b1;
                              end else begin
                                 idx    <= idx + 3'd1;
                                 data_q <= text_byte(idx + 3'd1, snap);
                              end
                           end
                           default: ;
                        endcase
                     end else begin
                        cnt <= cnt + 20'd1;
                     end
                  end
               endcase
            end
         endcase
      end
   end

   assign DATA_BUS = data_q;
   assign LCD_RW   = 1'b0;
   assign LCD_E    = e_q;
   assign LCD_RS   = rs_q;
   assign ready    = ready_q;

endmodule

// File: tb/tb_lcd_status_writer.sv
// Directed bench for lcd_status_writer with small timing parameters.
// A negedge monitor captures every E pulse ({RS, DATA}), its width and the
// E-low gap before it; the main sequence compares those against hand-built
// expected byte lists.
module tb_lcd_status_writer;

   localparam int INIT_WAIT = 20;
   localparam int E_HIGH    = 4;
   localparam int CMD_WAIT  = 10;
   localparam int CLR_WAIT  = 30;

   logic       clk = 1'b0;
   logic       reset;
   logic       t;
   logic       f;
   wire  [7:0] data_bus;
   logic       lcd_rw;
   logic       lcd_e;
   logic       lcd_rs;
   logic       ready;

   int n_vec  = 0;
   int n_miss = 0;

   logic [8:0] pulse_q[$];
   int         gap_q[$];
   logic [8:0] exp_q[$];

   lcd_status_writer #(
      .INIT_WAIT(INIT_WAIT), .E_HIGH(E_HIGH), .CMD_WAIT(CMD_WAIT), .CLR_WAIT(CLR_WAIT)
   ) dut (
      .clk_50MHZ(clk),
      .reset    (reset),
      .t        (t),
      .f        (f),
      .DATA_BUS (data_bus),
      .LCD_RW   (lcd_rw),
      .LCD_E    (lcd_e),
      .LCD_RS   (lcd_rs),
      .ready    (ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // E pulse monitor: width, stability while high, captured byte, low gap.
   logic       e_prev   = 1'b0;
   logic       rst_seen = 1'b0;
   logic [8:0] cap;
   int         hi_len = 0;
   int         lo_len = 0;
   always @(negedge clk) begin
      if (reset === 1'b1) rst_seen = 1'b1;
      if (lcd_e === 1'b1 && !e_prev) begin
         cap      = {lcd_rs, data_bus};
         hi_len   = 1;
         rst_seen = 1'b0;
         gap_q.push_back(lo_len);
      end else if (lcd_e === 1'b1) begin
         hi_len++;
         chk("stable_hi", int'({lcd_rs, data_bus}), int'(cap));
      end else if (e_prev) begin
         if (!rst_seen) begin
            chk("e_width", hi_len, E_HIGH);
            pulse_q.push_back(cap);
         end
         lo_len = 1;
      end else begin
         lo_len++;
      end
      e_prev = (lcd_e === 1'b1);
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clr();
      pulse_q.delete();
      gap_q.delete();
   endtask

   task automatic wait_ready(input string tag);
      int c = 0;
      while (ready !== 1'b1 && c < 5000) begin
         step(1);
         c++;
      end
      if (ready !== 1'b1) chk({tag, "_ready_timeout"}, 0, 1);
   endtask

   task automatic wait_e_byte(input logic [7:0] b);
      int c = 0;
      while (!(lcd_e === 1'b1 && data_bus == b) && c < 5000) begin
         step(1);
         c++;
      end
      if (lcd_e !== 1'b1) chk("e_byte_timeout", 0, 1);
   endtask

   task automatic time_first_rise(input string tag);
      int c = 0;
      while (lcd_e !== 1'b1 && c < 1000) begin
         step(1);
         c++;
      end
      chk(tag, c, INIT_WAIT + 2);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_e"},     int'(lcd_e),    0);
      chk({tag, "_rs"},    int'(lcd_rs),   0);
      chk({tag, "_rw"},    int'(lcd_rw),   0);
      chk({tag, "_data"},  int'(data_bus), 0);
      chk({tag, "_ready"}, int'(ready),    0);
   endtask

   // clr_idx: pulse index preceded by the long clear settle gap (-1 if none).
   task automatic check_seq(input string tag, input int clr_idx);
      int n;
      chk({tag, "_count"}, pulse_q.size(), exp_q.size());
      n = (pulse_q.size() < exp_q.size()) ? pulse_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_byte%0d", tag, i), int'(pulse_q[i]), int'(exp_q[i]));
         if (i > 0 && i < gap_q.size())
            chk($sformatf("%s_gap%0d", tag, i), gap_q[i],
                (i == clr_idx) ? CLR_WAIT + 2 : CMD_WAIT + 2);
      end
   endtask

   initial begin
      reset = 1'b1;
      t     = 1'b0;
      f     = 1'b0;

      // Test 1: reset values, power-up delay and full 12-pulse sequence.
      step(3);
      check_reset_vals("rst");
      reset = 1'b0;
      clr();
      time_first_rise("first_rise");
      wait_ready("t1");
      exp_q = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h080,
                9'h154, 9'h13D, 9'h130, 9'h120, 9'h146, 9'h13D, 9'h130};
      check_seq("t1", 3);
      chk("t1_ready", int'(ready), 1);
      step(50);
      chk("t1_quiet", pulse_q.size(), 12);
      clr();

      // Test 2: t rises in IDLE.
      t = 1'b1;
      step(1);
      chk("t2_ready_fall", int'(ready), 0);
      wait_ready("t2");
      exp_q = '{9'h080, 9'h154, 9'h13D, 9'h131, 9'h120, 9'h146, 9'h13D, 9'h130};
      check_seq("t2", -1);
      clr();

      // Test 3: t falls, f toggles during the refresh and ends changed.
      t = 1'b0;
      step(1);
      chk("t3_ready_fall", int'(ready), 0);
      step(10); f = 1'b1;
      step(20); f = 1'b0;
      step(20); f = 1'b1;
      wait_ready("t3a");
      exp_q = '{9'h080, 9'h154, 9'h13D, 9'h130, 9'h120, 9'h146, 9'h13D, 9'h130};
      check_seq("t3a", -1);
      clr();
      step(1);
      chk("t3_pending_fall", int'(ready), 0);
      wait_ready("t3b");
      exp_q = '{9'h080, 9'h154, 9'h13D, 9'h130, 9'h120, 9'h146, 9'h13D, 9'h131};
      check_seq("t3b", -1);
      clr();
      step(200);
      chk("t3_no_more", pulse_q.size(), 0);
      chk("t3_ready_hold", int'(ready), 1);

      // Test 4: f falls; t changes and is restored during the refresh.
      f = 1'b0;
      step(21); t = 1'b1;
      step(40); t = 1'b0;
      wait_ready("t4");
      exp_q = '{9'h080, 9'h154, 9'h13D, 9'h130, 9'h120, 9'h146, 9'h13D, 9'h130};
      check_seq("t4", -1);
      clr();
      step(200);
      chk("t4_no_more", pulse_q.size(), 0);
      chk("t4_ready_hold", int'(ready), 1);

      // Test 5: one-cycle reset during STROBE of the entry-mode byte.
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      clr();
      wait_e_byte(8'h06);
      step(1);
      reset = 1'b1;
      step(1);
      check_reset_vals("mid_rst");
      reset = 1'b0;
      clr();
      time_first_rise("rerun_rise");
      wait_ready("t5");
      exp_q = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h080,
                9'h154, 9'h13D, 9'h130, 9'h120, 9'h146, 9'h13D, 9'h130};
      check_seq("t5", 3);
      step(5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
